// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock circular FIFO.
//
// Parameters:
//   DATA_W    data width in bits
//   DEPTH     number of entries (power of two, >= 4)
//   AF_THRESH almost_full asserts when count >= AF_THRESH
//   AE_THRESH almost_empty asserts when count <= AE_THRESH
//   FWFT      0 = registered read, 1 = first-word-fall-through
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   write_en, buf_in  push request and data
//   read_en           pop request
//   clr_err           synchronous clear of the sticky error flags
//   buf_out           read data
//   out_valid         FWFT=0: one-cycle pulse after an accepted read
//                     FWFT=1: buf_out holds the head word
//   count             occupancy, 0..DEPTH
//   buffer_empty, buffer_full, almost_empty, almost_full
//                     occupancy flags, registered from the next-state count
//   overflow          sticky, a write was rejected
//   underflow         sticky, a read was rejected
module fifo_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned AF_THRESH = DEPTH - 4,
    parameter int unsigned AE_THRESH = 4,
    parameter bit          FWFT      = 1'b0,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [DATA_W-1:0] buf_in,
    input  logic              clr_err,
    output logic [DATA_W-1:0] buf_out,
    output logic              out_valid,
    output logic [CW-1:0]     count,
    output logic              buffer_empty,
    output logic              buffer_full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0] read_ptr_q, write_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, full_q, aempty_q, afull_q;
    logic          overflow_q, underflow_q;
    logic          rd_ok, wr_ok;

    always_comb begin
        rd_ok = read_en && !empty_q;
        // At full, a concurrent accepted read frees the slot being written.
        wr_ok = write_en && (!full_q || rd_ok);

        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_ptr_q  <= '0;
            write_ptr_q <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            aempty_q    <= (CW'(0) <= CW'(AE_THRESH));
            afull_q     <= (CW'(0) >= CW'(AF_THRESH));
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (rd_ok) begin
                read_ptr_q <= read_ptr_q + AW'(1);
            end
            if (wr_ok) begin
                write_ptr_q <= write_ptr_q + AW'(1);
            end
            count_q  <= count_d;
            // Flags come from count_d so they never lag count.
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == CW'(DEPTH));
            aempty_q <= (count_d <= CW'(AE_THRESH));
            afull_q  <= (count_d >= CW'(AF_THRESH));
            // Set takes priority over clear.
            overflow_q  <= (overflow_q && !clr_err) || (write_en && !wr_ok);
            underflow_q <= (underflow_q && !clr_err) || (read_en && !rd_ok);
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[write_ptr_q] <= buf_in;
        end
    end

    if (FWFT == 1'b0) begin : g_std
        logic [DATA_W-1:0] buf_out_q;
        logic              out_valid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                buf_out_q   <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= rd_ok;
                if (rd_ok) begin
                    buf_out_q <= mem[read_ptr_q];
                end
            end
        end

        assign buf_out   = buf_out_q;
        assign out_valid = out_valid_q;
    end else begin : g_fwft
        // Head word shown directly; forced to zero while empty so the
        // unreset memory never leaks onto buf_out (including during reset).
        assign buf_out   = empty_q ? '0 : mem[read_ptr_q];
        assign out_valid = !empty_q;
    end

    assign count        = count_q;
    assign buffer_empty = empty_q;
    assign buffer_full  = full_q;
    assign almost_empty = aempty_q;
    assign almost_full  = afull_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

    localparam int unsigned DW = 8;
    localparam int unsigned DP = 8;
    localparam int unsigned AF = 6;
    localparam int unsigned AE = 1;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_en, read_en, clr_err;
    logic [DW-1:0] buf_in;

    // Standard-mode instance
    logic [DW-1:0] s_buf_out;
    logic [CW-1:0] s_count;
    logic s_out_valid, s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
    // Fall-through instance, same stimulus
    logic [DW-1:0] f_buf_out;
    logic [CW-1:0] f_count;
    logic f_out_valid, f_empty, f_full, f_ae, f_af, f_ovf, f_unf;

    fifo_param #(
        .DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
        .buf_in(buf_in), .clr_err(clr_err), .buf_out(s_buf_out),
        .out_valid(s_out_valid), .count(s_count), .buffer_empty(s_empty),
        .buffer_full(s_full), .almost_empty(s_ae), .almost_full(s_af),
        .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_param #(
        .DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)
    ) dut_f (
        .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
        .buf_in(buf_in), .clr_err(clr_err), .buf_out(f_buf_out),
        .out_valid(f_out_valid), .count(f_count), .buffer_empty(f_empty),
        .buffer_full(f_full), .almost_empty(f_ae), .almost_full(f_af),
        .overflow(f_ovf), .underflow(f_unf)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: a queue of stored words plus sticky flags.
    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf, m_vld;
    logic [DW-1:0] m_out;

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        m_vld = 0;
        m_out = '0;
    endtask

    task automatic model_step();
        int n;
        bit rok, wok;
        n   = q.size();
        rok = read_en && (n > 0);
        wok = write_en && ((n < DP) || rok);
        m_vld = rok;
        if (rok) m_out = q.pop_front();
        if (wok) q.push_back(buf_in);
        m_ovf = (m_ovf && !clr_err) || (write_en && !wok);
        m_unf = (m_unf && !clr_err) || (read_en && !rok);
    endtask

    task automatic model_check();
        int n;
        logic [DW-1:0] head;
        n    = q.size();
        head = (n > 0) ? q[0] : '0;
        check("count",     32'(s_count),     32'(n));
        check("empty",     32'(s_empty),     32'(n == 0));
        check("full",      32'(s_full),      32'(n == DP));
        check("almost_e",  32'(s_ae),        32'(n <= AE));
        check("almost_f",  32'(s_af),        32'(n >= AF));
        check("overflow",  32'(s_ovf),       32'(m_ovf));
        check("underflow", 32'(s_unf),       32'(m_unf));
        check("out_valid", 32'(s_out_valid), 32'(m_vld));
        check("buf_out",   32'(s_buf_out),   32'(m_out));
        check("f_count",   32'(f_count),     32'(n));
        check("f_ovf",     32'(f_ovf),       32'(m_ovf));
        check("f_unf",     32'(f_unf),       32'(m_unf));
        check("f_valid",   32'(f_out_valid), 32'(n > 0));
        check("f_buf_out", 32'(f_buf_out),   32'(head));
    endtask

    // Inputs change 1 time unit after an edge; sample 1 unit after the next edge.
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
        write_en = w;
        read_en  = r;
        buf_in   = d;
        clr_err  = c;
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"}, 32'(s_count), 32'd0);
        check({tag, "_empty"}, 32'(s_empty), 32'd1);
        check({tag, "_ae"},    32'(s_ae),    32'd1);
        check({tag, "_full"},  32'(s_full),  32'd0);
        check({tag, "_af"},    32'(s_af),    32'd0);
        check({tag, "_out"},   32'(s_buf_out), 32'd0);
        check({tag, "_vld"},   32'(s_out_valid), 32'd0);
        check({tag, "_ovf"},   32'(s_ovf),   32'd0);
        check({tag, "_unf"},   32'(s_unf),   32'd0);
        check({tag, "_fvld"},  32'(f_out_valid), 32'd0);
        check({tag, "_fout"},  32'(f_buf_out), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        write_en = 0; read_en = 0; clr_err = 0; buf_in = '0;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int we; int re; int din;
        int cnt; int full; int af; int empty; int ae; int dout; int vld;
    } vec_t;

    vec_t vec[16];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //           we re din    cnt full af emp ae dout  vld
        vec[0]  = '{1, 0, 'h10,  1, 0, 0, 0, 1, 'h00, 0};
        vec[1]  = '{1, 0, 'h11,  2, 0, 0, 0, 0, 'h00, 0};
        vec[2]  = '{1, 0, 'h12,  3, 0, 0, 0, 0, 'h00, 0};
        vec[3]  = '{1, 0, 'h13,  4, 0, 0, 0, 0, 'h00, 0};
        vec[4]  = '{1, 0, 'h14,  5, 0, 0, 0, 0, 'h00, 0};
        vec[5]  = '{1, 0, 'h15,  6, 0, 1, 0, 0, 'h00, 0};
        vec[6]  = '{1, 0, 'h16,  7, 0, 1, 0, 0, 'h00, 0};
        vec[7]  = '{1, 0, 'h17,  8, 1, 1, 0, 0, 'h00, 0};
        vec[8]  = '{0, 1, 'h00,  7, 0, 1, 0, 0, 'h10, 1};
        vec[9]  = '{0, 1, 'h00,  6, 0, 1, 0, 0, 'h11, 1};
        vec[10] = '{0, 1, 'h00,  5, 0, 0, 0, 0, 'h12, 1};
        vec[11] = '{0, 1, 'h00,  4, 0, 0, 0, 0, 'h13, 1};
        vec[12] = '{0, 1, 'h00,  3, 0, 0, 0, 0, 'h14, 1};
        vec[13] = '{0, 1, 'h00,  2, 0, 0, 0, 0, 'h15, 1};
        vec[14] = '{0, 1, 'h00,  1, 0, 0, 0, 1, 'h16, 1};
        vec[15] = '{0, 1, 'h00,  0, 0, 0, 1, 1, 'h17, 1};

        rst = 1'b1;
        write_en = 0; read_en = 0; clr_err = 0; buf_in = '0;
        model_reset();
        #1;
        check_reset_values("rst_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("rst_init");

        // Fill and drain, table-driven
        for (int i = 0; i < 16; i++) begin
            cycle(vec[i].we != 0, vec[i].re != 0, DW'(vec[i].din), 1'b0);
            check($sformatf("tbl%0d_cnt", i),   32'(s_count),     32'(vec[i].cnt));
            check($sformatf("tbl%0d_full", i),  32'(s_full),      32'(vec[i].full));
            check($sformatf("tbl%0d_af", i),    32'(s_af),        32'(vec[i].af));
            check($sformatf("tbl%0d_empty", i), 32'(s_empty),     32'(vec[i].empty));
            check($sformatf("tbl%0d_ae", i),    32'(s_ae),        32'(vec[i].ae));
            check($sformatf("tbl%0d_out", i),   32'(s_buf_out),   32'(vec[i].dout));
            check($sformatf("tbl%0d_vld", i),   32'(s_out_valid), 32'(vec[i].vld));
        end

        // Wrap-around
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, '0, 1'b0);
            check($sformatf("wrap%0d", i), 32'(s_buf_out), 32'(8'hA0 + i));
        end
        check("wrap_ovf", 32'(s_ovf), 32'd0);
        check("wrap_unf", 32'(s_unf), 32'd0);

        // Simultaneous read+write at full
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(8'h20 + i), 1'b0);
        cycle(1'b1, 1'b1, 8'h55, 1'b0);
        check("pass_cnt", 32'(s_count), 32'd8);
        check("pass_ovf", 32'(s_ovf),   32'd0);
        check("pass_out", 32'(s_buf_out), 32'h20);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0, 1'b0);
        check("pass_last", 32'(s_buf_out), 32'h55);

        // Simultaneous at empty: write accepted, read rejected
        cycle(1'b1, 1'b1, 8'h66, 1'b0);
        check("empty_both_cnt", 32'(s_count),     32'd1);
        check("empty_both_unf", 32'(s_unf),       32'd1);
        check("empty_both_vld", 32'(s_out_valid), 32'd0);
        cycle(1'b0, 1'b1, '0, 1'b1);
        check("empty_both_out", 32'(s_buf_out), 32'h66);
        check("unf_cleared",    32'(s_unf),     32'd0);

        // Overflow: sticky, no memory corruption, set beats clear
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(8'h30 + i), 1'b0);
        cycle(1'b1, 1'b0, 8'hEE, 1'b0);
        check("ovf_set", 32'(s_ovf),   32'd1);
        check("ovf_cnt", 32'(s_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, '0, 1'b0);
            check($sformatf("ovf_mem%0d", i), 32'(s_buf_out), 32'(8'h30 + i));
            check($sformatf("ovf_hold%0d", i), 32'(s_ovf), 32'd1);
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(8'h50 + i), 1'b0);
        cycle(1'b1, 1'b0, 8'hEF, 1'b1);
        check("ovf_set_wins", 32'(s_ovf), 32'd1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        check("ovf_clear", 32'(s_ovf), 32'd0);

        // Fall-through mode
        do_reset();
        cycle(1'b1, 1'b0, 8'h3C, 1'b0);
        check("fwft_out", 32'(f_buf_out),   32'h3C);
        check("fwft_vld", 32'(f_out_valid), 32'd1);
        cycle(1'b0, 1'b1, '0, 1'b0);
        check("fwft_pop_vld",   32'(f_out_valid), 32'd0);
        check("fwft_pop_empty", 32'(f_empty),     32'd1);

        // Asynchronous reset with words stored
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, DW'(8'h41 + i), 1'b0);
        #2;
        write_en = 0; read_en = 0;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_values("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 1'b0, 8'h99, 1'b0);
        check("post_rst_fwft", 32'(f_buf_out), 32'h99);
        cycle(1'b0, 1'b1, '0, 1'b0);
        check("post_rst_out", 32'(s_buf_out), 32'h99);
        check("post_rst_vld", 32'(s_out_valid), 32'd1);

        // Randomised traffic against the queue model, alternating bias
        for (int i = 0; i < 600; i++) begin
            bool_phase: begin
                bit wbias;
                int wr_pct, rd_pct;
                wbias  = ((i / 40) % 2) == 0;
                wr_pct = wbias ? 75 : 30;
                rd_pct = wbias ? 30 : 75;
                cycle($urandom_range(99) < wr_pct, $urandom_range(99) < rd_pct,
                      DW'($urandom), $urandom_range(15) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
